// File: rtl/scq_pkg.sv
// Shared widths, default depth and entry layout for the store commit queue.
// No logic; widths here size every port and entry in the queue.
// Backpressure: n/a.
package scq_pkg;

    localparam int SCQ_DEPTH_DEF = 4;
    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int SCQ_PTR_W     = $clog2(SCQ_DEPTH_DEF) + 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } scq_entry_t;

endpackage

// File: rtl/scq_fwd_match.sv
// Store-to-load forwarding: youngest matching store wins, committing store first.
// Latency: purely combinational, zero cycles.
// Backpressure: none; pure lookup.
module scq_fwd_match
    import scq_pkg::*;
#(
    parameter  int DEPTH = SCQ_DEPTH_DEF,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int OCC_W = IDX_W + 1
) (
    input  scq_entry_t [DEPTH-1:0] entries,
    input  logic [IDX_W:0]         head,
    input  logic [IDX_W:0]         tail,
    input  logic                   commit_en,
    input  logic [ADDR_W-1:0]      commit_addr,
    input  logic [DATA_W-1:0]      commit_data,
    input  logic [ADDR_W-1:0]      fwd_addr,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);

    logic [OCC_W-1:0] occ;
    logic [IDX_W-1:0] idx;

    // Walk oldest to youngest so later matches overwrite earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        occ  = tail - head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head[IDX_W-1:0] + IDX_W'(k);
            if ((OCC_W'(k) < occ) && entries[idx].valid && (entries[idx].addr == fwd_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
        if (commit_en && (commit_addr == fwd_addr)) begin
            hit  = 1'b1;
            data = commit_data;
        end
    end

endmodule

// File: rtl/store_commit_queue.sv
// Buffers committed stores until memory accepts them, forwarding to younger loads.
// Latency: enqueue at edge N is presented on mem_* during cycle N+1; no bypass.
// Backpressure: full stalls ROB store commit; mem_ready low freezes the head.
module store_commit_queue
    import scq_pkg::*;
#(
    parameter  int DEPTH = SCQ_DEPTH_DEF,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_addr,
    input  logic [DATA_W-1:0] commit_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
);

    scq_entry_t [DEPTH-1:0] entries_q;
    logic [IDX_W:0]         head_q;
    logic [IDX_W:0]         tail_q;
    logic                   full_q;
    logic                   empty_q;
    logic [CNT_W-1:0]       count_q;
    logic                   overflow_q;
    logic                   mem_wen_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;

    logic                   enq;
    logic                   deq;
    logic [IDX_W:0]         head_nx;
    logic [IDX_W:0]         tail_nx;
    logic [CNT_W-1:0]       count_nx;
    logic [IDX_W-1:0]       head_nx_idx;
    logic [ADDR_W-1:0]      head_nx_addr;
    logic [DATA_W-1:0]      head_nx_data;

    // Full is judged on the registered count only: a same-cycle drain never frees a slot early.
    assign enq      = commit_valid && !full_q;
    assign deq      = mem_wen_q && mem_ready;
    assign head_nx  = head_q + CNT_W'(deq);
    assign tail_nx  = tail_q + CNT_W'(enq);
    assign count_nx = tail_nx - head_nx;
    assign head_nx_idx = head_nx[IDX_W-1:0];

    // The slot at the old tail is free, so a new head landing there must be the incoming store.
    always_comb begin
        head_nx_addr = entries_q[head_nx_idx].addr;
        head_nx_data = entries_q[head_nx_idx].data;
        if (enq && (head_nx_idx == tail_q[IDX_W-1:0])) begin
            head_nx_addr = commit_addr;
            head_nx_data = commit_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if (enq) begin
                entries_q[tail_q[IDX_W-1:0]] <= '{valid: 1'b1, addr: commit_addr, data: commit_data};
            end
            if (deq) begin
                entries_q[head_q[IDX_W-1:0]].valid <= 1'b0;
            end
            if (commit_valid && full_q) begin
                overflow_q <= 1'b1;
            end
            head_q    <= head_nx;
            tail_q    <= tail_nx;
            count_q   <= count_nx;
            full_q    <= (count_nx == CNT_W'(DEPTH));
            empty_q   <= (count_nx == '0);
            mem_wen_q <= (count_nx != '0);
            // Memory port keeps the last head value once the queue drains.
            if (count_nx != '0) begin
                mem_addr_q  <= head_nx_addr;
                mem_wdata_q <= head_nx_data;
            end
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    scq_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
        .entries     (entries_q),
        .head        (head_q),
        .tail        (tail_q),
        .commit_en   (enq),
        .commit_addr (commit_addr),
        .commit_data (commit_data),
        .fwd_addr    (fwd_addr),
        .hit         (fwd_hit),
        .data        (fwd_data)
    );

endmodule

// File: tb/tb_store_commit_queue.sv
// Randomized and directed checks of store_commit_queue against a queue-based model.
module tb_store_commit_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        commit_valid;
    logic [31:0] commit_addr;
    logic [31:0] commit_data;
    logic        full;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    store_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_addr  (commit_addr),
        .commit_data  (commit_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .fwd_addr     (fwd_addr),
        .fwd_hit      (fwd_hit),
        .fwd_data     (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    st_t         mq[$];
    logic        m_ovf    = 1'b0;
    logic [31:0] m_last_a = '0;
    logic [31:0] m_last_d = '0;
    logic [31:0] wlog[$];
    int          checks   = 0;
    int          errors   = 0;
    bit          m_full;
    bit          m_enq;
    bit          m_deq;
    st_t         m_new;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue contents are just the committed-but-unwritten stores in order.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovf    = 1'b0;
            m_last_a = '0;
            m_last_d = '0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_enq  = commit_valid && !m_full;
            m_deq  = (mq.size() != 0) && mem_ready;
            if (commit_valid && m_full) m_ovf = 1'b1;
            if (m_deq) begin
                m_last_a = mq[0].a;
                m_last_d = mq[0].d;
                void'(mq.pop_front());
            end
            if (m_enq) begin
                m_new.a = commit_addr;
                m_new.d = commit_data;
                mq.push_back(m_new);
            end
        end
    end

    function automatic void model_fwd(output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (commit_valid && (mq.size() < DEPTH) && (commit_addr == fwd_addr)) begin
            h = 1'b1;
            d = commit_data;
            return;
        end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == fwd_addr) begin
                h = 1'b1;
                d = mq[i].d;
                return;
            end
        end
    endfunction

    // Per-cycle compare, mid-cycle with inputs stable.
    always @(negedge clk) begin
        logic        eh;
        logic [31:0] ed;
        model_fwd(eh, ed);
        check("empty",    empty,    mq.size() == 0);
        check("full",     full,     mq.size() == DEPTH);
        check("count",    count,    mq.size());
        check("overflow", overflow, m_ovf);
        check("mem_wen",  mem_wen,  mq.size() != 0);
        check("mem_addr", mem_addr, (mq.size() != 0) ? mq[0].a : m_last_a);
        check("mem_wdata", mem_wdata, (mq.size() != 0) ? mq[0].d : m_last_d);
        check("fwd_hit",  fwd_hit,  eh);
        check("fwd_data", fwd_data, ed);
        if (rst && mem_wen && mem_ready) wlog.push_back(mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        commit_valid = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic commit(input logic [31:0] a, input logic [31:0] d);
        commit_valid = 1'b1;
        commit_addr  = a;
        commit_data  = d;
        tick();
        commit_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        commit_valid = 1'b0;
        commit_addr  = '0;
        commit_data  = '0;
        mem_ready    = 1'b0;
        fwd_addr     = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_wen", mem_wen, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hit", fwd_hit, 0);
        check("rst_fdata", fwd_data, 0);
        rst = 1'b1;
        tick();

        // Three commits held off memory, then drained in order.
        wlog.delete();
        commit(32'h10, 32'h1);
        commit(32'h11, 32'h2);
        commit(32'h12, 32'h3);
        check("t1_count", count, 3);
        check("t1_addr", mem_addr, 32'h10);
        tick();
        check("t1_hold", mem_addr, 32'h10);
        mem_ready = 1'b1;
        tick();
        check("t1_addr1", mem_addr, 32'h11);
        tick();
        check("t1_addr2", mem_addr, 32'h12);
        tick();
        check("t1_empty", empty, 1);
        check("t1_wen", mem_wen, 0);
        check("t1_held", mem_addr, 32'h12);
        check("t1_nwr", wlog.size(), 3);
        for (int i = 0; i < 3 && i < wlog.size(); i++) check("t1_wr", wlog[i], 32'h10 + i);
        mem_ready = 1'b0;

        // Fill and overflow with memory stalled.
        do_reset();
        for (int i = 0; i < 4; i++) commit(32'h30 + i, i);
        check("t2_full", full, 1);
        commit(32'h99, 32'h99);
        check("t2_ovf", overflow, 1);
        check("t2_count", count, 4);
        do_reset();
        check("t2_ovf_clr", overflow, 0);
        for (int i = 0; i < 4; i++) commit(32'h30 + i, i);
        mem_ready = 1'b1;
        commit(32'h99, 32'h99);
        check("t2b_count", count, 3);
        check("t2b_ovf", overflow, 1);
        check("t2b_addr", mem_addr, 32'h31);
        mem_ready = 1'b0;

        // Forwarding priority.
        do_reset();
        commit(32'h20, 32'hAA);
        commit(32'h20, 32'hBB);
        fwd_addr = 32'h20;
        #1;
        check("t3_hit", fwd_hit, 1);
        check("t3_data", fwd_data, 32'hBB);
        commit_valid = 1'b1;
        commit_addr  = 32'h20;
        commit_data  = 32'hCC;
        #1;
        check("t3_cdata", fwd_data, 32'hCC);
        fwd_addr = 32'h21;
        #1;
        check("t3_miss", fwd_hit, 0);
        check("t3_mdata", fwd_data, 0);
        commit_valid = 1'b0;
        tick();

        // Continuous commit and drain across pointer wrap.
        do_reset();
        wlog.delete();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) commit(32'h100 + i, i * 7);
        repeat (3) tick();
        check("t4_nwr", wlog.size(), 10);
        for (int i = 0; i < 10 && i < wlog.size(); i++) check("t4_wr", wlog[i], 32'h100 + i);
        check("t4_empty", empty, 1);
        mem_ready = 1'b0;

        // Asynchronous reset with stores queued.
        do_reset();
        commit(32'h40, 32'h1);
        commit(32'h41, 32'h2);
        rst = 1'b0;
        #1;
        check("t5_empty", empty, 1);
        check("t5_wen", mem_wen, 0);
        check("t5_count", count, 0);
        #2;
        rst = 1'b1;
        tick();
        commit(32'h55, 32'h66);
        check("t5_wen2", mem_wen, 1);
        check("t5_addr", mem_addr, 32'h55);
        check("t5_wdata", mem_wdata, 32'h66);

        // Randomized traffic checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                commit_valid = ($urandom_range(0, 99) < 60);
                commit_addr  = 32'h40 + $urandom_range(0, 7);
                commit_data  = $urandom;
                mem_ready    = ($urandom_range(0, 99) < ((c < 1500) ? 70 : 30));
                fwd_addr     = 32'h40 + $urandom_range(0, 7);
                tick();
            end
        end
        commit_valid = 1'b0;
        mem_ready    = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_commit_queue.md
# store_commit_queue

Holds committed store (`sw`) instructions between ROB commit and data memory, so stores write memory only after they become architectural. It sits downstream of the ROB commit port and upstream of the data memory write port. It drains one store per cycle whenever memory accepts, and forwards the youngest matching store data to loads issued from the load/store buffer.

## Interface
- `DEPTH`, 4: number of entries; power of two, 2..16.
- `ADDR_W`, 32: effective-address width (word addresses).
- `DATA_W`, 32: store data width.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `commit_valid`  in  1  ROB is committing a `sw` this cycle.
- `commit_addr`  in  ADDR_W  effective address of the committing store.
- `commit_data`  in  DATA_W  store data of the committing store.
- `full`  out  1  no free entry; ROB must hold `sw` commit while high.
- `empty`  out  1  no entries; halt logic waits for `empty` before stopping the clock.
- `count`  out  $clog2(DEPTH)+1  number of occupied entries.
- `overflow`  out  1  sticky; set when `commit_valid` arrives while `full`.
- `mem_wen`  out  1  head entry valid and presented to memory.
- `mem_addr`  out  ADDR_W  head entry address.
- `mem_wdata`  out  DATA_W  head entry data.
- `mem_ready`  in  1  memory accepts the write this cycle; low when a load owns the port.
- `fwd_addr`  in  ADDR_W  address of the load being looked up.
- `fwd_hit`  out  1  a queued or committing store matches `fwd_addr`.
- `fwd_data`  out  DATA_W  data of the youngest matching store.

## Operation
- Circular buffer with `head` and `tail` pointers, each `$clog2(DEPTH)` bits plus one wrap bit.
  - `empty` = pointers equal.
  - `full` = indices equal and wrap bits differ.
  - `count` = `tail - head`, modulo 2·DEPTH.
- Enqueue:
  - Condition: `commit_valid && !full`.
  - Writes addr/data at `tail`, sets the entry valid, increments `tail`.
- Dequeue:
  - Condition: `mem_wen && mem_ready`.
  - Clears the head valid bit and increments `head`.
- `full` is evaluated on the current count only, with no pass-through:
  - An enqueue while full is refused even if a dequeue occurs in the same cycle.
  - The refused enqueue sets `overflow`, which stays set until reset.
- Enqueue and dequeue in the same cycle are both performed; `count` is unchanged.
- The memory port is driven directly from the head entry:
  - `mem_wen` = `!empty`.
  - When empty, `mem_addr` and `mem_wdata` are don't-care but held at the last head value.
- Forwarding is combinational:
  - Compare `fwd_addr` against all valid entries and against `commit_addr` when an enqueue is happening.
  - Priority order: the committing store first, then the entry nearest `tail`, down to `head`.
  - When nothing matches, `fwd_hit` = 0 and `fwd_data` = 0.
- ROB flush has no effect; all entries are already committed.
- No address validity check here; memory reports invalid addresses.

## Timing
- Reset (asynchronous, `rst` low) sets:
  - head = tail = 0 and all valid bits = 0;
  - `empty` = 1, `full` = 0, `count` = 0, `overflow` = 0;
  - `mem_wen` = 0, `fwd_hit` = 0, `mem_addr`/`mem_wdata`/`fwd_data` = 0.
- Reset mid-operation discards every queued store.
- Commit-to-memory latency:
  - 1 cycle: an enqueue at edge N gives `mem_wen` = 1 during cycle N+1.
  - There is no empty-queue bypass.
- Drain throughput is 1 store per cycle while `mem_ready` = 1.
- `mem_ready` low holds all `mem_*` outputs stable; head does not move.
- Pointer wrap: the index returns to 0 after DEPTH-1 and the wrap bit toggles.
- `full`, `empty` and `count` are register-derived and glitch-free after each edge.
- The forwarding path is fully combinational with zero-cycle latency; it is a critical path into the load/store buffer.

## Structure
- Shared package `scq_pkg`:
  - `SCQ_DEPTH_DEF`, `ADDR_W`, `DATA_W`;
  - pointer-width localparam;
  - packed entry typedef {valid, addr, data}.
- One sub-module, `scq_fwd_match`:
  - Inputs: entry array, head/tail, the committing store, `fwd_addr`.
  - Outputs: hit and data, via age-ordered priority select.
- Top level holds the pointers, storage, overflow flag and memory-port assignment.

## Test plan
- Reset, then 3 commits (A0=0x10/D=0x1, 0x11/0x2, 0x12/0x3) with `mem_ready` = 0:
  - `count` = 3, `mem_addr` = 0x10 held.
  - Raise `mem_ready`: writes 0x10, 0x11, 0x12 on consecutive cycles, then `empty` = 1.
- Fill 4 entries with `mem_ready` = 0:
  - `full` = 1.
  - A 5th commit sets `overflow` = 1 and leaves `count` = 4.
  - The same case with `mem_ready` = 1 refuses the 5th commit and gives `count` = 3.
- Stores 0x20/0xAA then 0x20/0xBB queued, `fwd_addr` = 0x20:
  - `fwd_hit` = 1, `fwd_data` = 0xBB.
  - Same-cycle commit 0x20/0xCC gives `fwd_data` = 0xCC.
  - `fwd_addr` = 0x21 gives `fwd_hit` = 0.
- Commit and drain continuously for 10 stores with DEPTH = 4:
  - Pointers wrap.
  - Memory receives all 10 in order, with no loss or duplication.
- Assert `rst` low with 2 entries queued:
  - Immediately `empty` = 1, `mem_wen` = 0.
  - After release, a new commit appears at `mem_addr` one cycle later.
